// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle control sequencer driving datapath strobes per instruction phase
module cpu_sequencer #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       op,
   input  logic             zero,
   input  logic             sign,
   input  logic             mem_ready,
   output logic             ir_load,
   output logic             pc_inc,
   output logic             RegDst,
   output logic             ALUSrc,
   output logic             Mem2Reg,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             RegWrite,
   output logic             PCSrc,
   output logic             push,
   output logic             pop,
   output logic [4:0]       ALUOp,
   output logic             halt,
   output logic             bus_err,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_STACK  = 3'd5;
   localparam logic [2:0] S_HALT   = 3'd6;

   localparam logic [3:0] C_ALU_R = 4'd0;
   localparam logic [3:0] C_ALU_I = 4'd1;
   localparam logic [3:0] C_LD    = 4'd2;
   localparam logic [3:0] C_ST    = 4'd3;
   localparam logic [3:0] C_BR    = 4'd4;
   localparam logic [3:0] C_CALL  = 4'd5;
   localparam logic [3:0] C_RET   = 4'd6;
   localparam logic [3:0] C_PUSH  = 4'd7;
   localparam logic [3:0] C_POP   = 4'd8;
   localparam logic [3:0] C_HALT  = 4'd9;
   localparam logic [3:0] C_ILL   = 4'd10;

   // Wait counter only needs to reach MEM_TIMEOUT; the timeout fires on that value.
   localparam int              WAIT_W   = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

   function automatic logic [3:0] op_class(input logic [5:0] o);
      logic [3:0] c;
      casez (o)
         6'b00????: c = C_ALU_R;
         6'b01????: c = C_ALU_I;
         6'b100000: c = C_LD;
         6'b100001: c = C_ST;
         6'b101???: c = C_BR;
         6'b110000: c = C_CALL;
         6'b110001: c = C_RET;
         6'b110010: c = C_PUSH;
         6'b110011: c = C_POP;
         6'b111111: c = C_HALT;
         default:   c = C_ILL;
      endcase
      return c;
   endfunction

   logic [2:0]        state_q, state_d;
   logic [5:0]        op_q, op_d;
   logic [WAIT_W-1:0] wcnt_q, wcnt_d;
   logic              bus_err_q, bus_err_d;
   logic              illegal_q, illegal_d;
   logic [CNT_W-1:0]  retired_q, retired_d;
   logic              retire;
   logic              taken;
   logic [3:0]        cls_q;
   logic [3:0]        cls_in;

   logic ir_load_c, pc_inc_c, reg_dst_c, alu_src_c, mem2reg_c, mem_read_c;
   logic mem_write_c, reg_write_c, pc_src_c, push_c, pop_c, halt_c;
   logic [4:0] alu_op_c;

   assign cls_q  = op_class(op_q);
   assign cls_in = op_class(op);

   // Branch condition from the latched condition code and the live ALU flags
   always_comb begin
      taken = 1'b0;
      case (op_q[2:0])
         3'b000:  taken = 1'b1;
         3'b001:  taken = zero;
         3'b010:  taken = ~zero;
         3'b011:  taken = sign;
         3'b100:  taken = ~sign;
         3'b101:  taken = ~sign & ~zero;
         default: taken = 1'b0;
      endcase
   end

   // Next-state, per-state strobes and retire pulse
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      wcnt_d      = wcnt_q;
      bus_err_d   = bus_err_q;
      illegal_d   = illegal_q;
      retire      = 1'b0;
      ir_load_c   = 1'b0;
      pc_inc_c    = 1'b0;
      reg_dst_c   = 1'b0;
      alu_src_c   = 1'b0;
      mem2reg_c   = 1'b0;
      mem_read_c  = 1'b0;
      mem_write_c = 1'b0;
      reg_write_c = 1'b0;
      pc_src_c    = 1'b0;
      push_c      = 1'b0;
      pop_c       = 1'b0;
      halt_c      = 1'b0;
      alu_op_c    = 5'b00000;
      case (state_q)
         S_FETCH: begin
            ir_load_c = 1'b1;
            pc_inc_c  = 1'b1;
            state_d   = S_DECODE;
         end
         S_DECODE: begin
            op_d = op;
            case (cls_in)
               C_ALU_R, C_ALU_I, C_LD, C_ST, C_BR: state_d = S_EXEC;
               C_CALL, C_RET, C_PUSH, C_POP:       state_d = S_STACK;
               C_HALT: begin
                  state_d = S_HALT;
                  retire  = 1'b1;
               end
               default: begin
                  // Undefined opcodes retire as a NOP and flag the event.
                  illegal_d = 1'b1;
                  retire    = 1'b1;
                  state_d   = S_FETCH;
               end
            endcase
         end
         S_EXEC: begin
            wcnt_d = '0;
            case (cls_q)
               C_ALU_R: begin
                  alu_op_c = {1'b0, op_q[3:0]};
                  state_d  = S_WB;
               end
               C_ALU_I: begin
                  alu_op_c  = {1'b0, op_q[3:0]};
                  alu_src_c = 1'b1;
                  state_d   = S_WB;
               end
               C_LD, C_ST: begin
                  alu_src_c = 1'b1;
                  state_d   = S_MEM;
               end
               C_BR: begin
                  alu_op_c = 5'b00001;
                  pc_src_c = taken;
                  retire   = 1'b1;
                  state_d  = S_FETCH;
               end
               default: state_d = S_FETCH;
            endcase
         end
         S_MEM: begin
            mem_read_c  = (cls_q == C_LD);
            mem_write_c = (cls_q == C_ST);
            if (mem_ready) begin
               if (cls_q == C_LD) begin
                  state_d = S_WB;
               end else begin
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
            end else if (wcnt_q == WAIT_MAX) begin
               bus_err_d = 1'b1;
               state_d   = S_HALT;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
         end
         S_WB: begin
            reg_write_c = 1'b1;
            reg_dst_c   = (cls_q == C_ALU_R);
            mem2reg_c   = (cls_q == C_LD);
            retire      = 1'b1;
            state_d     = S_FETCH;
         end
         S_STACK: begin
            push_c      = (cls_q == C_PUSH) || (cls_q == C_CALL);
            pop_c       = (cls_q == C_POP)  || (cls_q == C_RET);
            pc_src_c    = (cls_q == C_CALL) || (cls_q == C_RET);
            reg_write_c = (cls_q == C_POP);
            mem2reg_c   = (cls_q == C_POP);
            retire      = 1'b1;
            state_d     = S_FETCH;
         end
         S_HALT: begin
            halt_c = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
      retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
   end

   // Sequencer registers; reset returns to FETCH with all sticky flags cleared
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_FETCH;
         op_q      <= '0;
         wcnt_q    <= '0;
         bus_err_q <= 1'b0;
         illegal_q <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         wcnt_q    <= wcnt_d;
         bus_err_q <= bus_err_d;
         illegal_q <= illegal_d;
         retired_q <= retired_d;
      end
   end

   // Strobes are gated by reset so they drop the instant reset asserts,
   // even though the state register already reads FETCH.
   assign ir_load  = reset & ir_load_c;
   assign pc_inc   = reset & pc_inc_c;
   assign RegDst   = reset & reg_dst_c;
   assign ALUSrc   = reset & alu_src_c;
   assign Mem2Reg  = reset & mem2reg_c;
   assign MemRead  = reset & mem_read_c;
   assign MemWrite = reset & mem_write_c;
   assign RegWrite = reset & reg_write_c;
   assign PCSrc    = reset & pc_src_c;
   assign push     = reset & push_c;
   assign pop      = reset & pop_c;
   assign halt     = reset & halt_c;
   assign ALUOp    = {5{reset}} & alu_op_c;
   assign bus_err  = bus_err_q;
   assign illegal  = illegal_q;
   assign retired  = retired_q;

endmodule
